// File: rtl/sd_avg_scale.sv
// sd_avg_scale
//   Combinational output scaler for sd_avg_decim. Takes the full-width window
//   sum and reduces it to the output width by dropping SHIFT = ACC_W-WIDTH_OUT
//   low bits.
//
//   Optional feature macro: SD_AVG_DECIM_ROUND_EN
//     undefined : arithmetic shift right (truncate toward minus infinity).
//     defined   : round half up before the shift. A positive overflow of the
//                 rounded value is clipped to the largest output code.
//   When SHIFT == 0 the sum passes through unchanged in either build.
//
// Parameters
//   ACC_W     : width of the signed sum
//   WIDTH_OUT : width of the signed scaled result
// Ports
//   sum    (in)  : signed window sum, ACC_W bits
//   scaled (out) : signed scaled result, WIDTH_OUT bits
module sd_avg_scale #(
    parameter int ACC_W     = 8,
    parameter int WIDTH_OUT = 8
) (
    input  logic signed [ACC_W-1:0]     sum,
    output logic        [WIDTH_OUT-1:0] scaled
);

    localparam int SHIFT = ACC_W - WIDTH_OUT;

    // The output cannot be wider than the sum it is derived from.
    if (SHIFT < 0) begin : g_bad_width
        $error("sd_avg_scale: WIDTH_OUT must not exceed ACC_W");
    end

`ifdef SD_AVG_DECIM_ROUND_EN
    if (SHIFT > 0) begin : g_round
        // One extra headroom bit so that adding the half-LSB cannot wrap.
        localparam logic signed [ACC_W:0] HALF =
            $signed({{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1));
        localparam logic signed [ACC_W:0] MAX_POS =
            $signed({{(ACC_W - WIDTH_OUT + 2){1'b0}}, {(WIDTH_OUT - 1){1'b1}}});
        localparam logic [WIDTH_OUT-1:0] MAX_OUT = {1'b0, {(WIDTH_OUT - 1){1'b1}}};

        logic signed [ACC_W:0] rounded;

        assign rounded = ($signed({sum[ACC_W-1], sum}) + HALF) >>> SHIFT;

        // Rounding only ever moves the value upward, so only the positive
        // side needs clipping.
        assign scaled = (rounded > MAX_POS) ? MAX_OUT : WIDTH_OUT'(rounded);
    end else begin : g_pass
        assign scaled = WIDTH_OUT'(sum);
    end
`else
    assign scaled = WIDTH_OUT'(sum >>> SHIFT);
`endif

endmodule

// File: rtl/sd_avg_decim.sv
// sd_avg_decim
//   Receiving end of a narrow noise-shaped sample stream. Sums N = 2^LOG2_N
//   accepted input samples and emits one reconstructed, wider sample per
//   window together with a single-cycle strobe. The sum is reduced to the
//   output width by sd_avg_scale.
//
//   Optional feature macro: SD_AVG_DECIM_ROUND_EN (round-half-up with positive
//   clip in the scaler instead of plain truncation).
//
// Parameters
//   WIDTH_IN  : width of the signed narrow input samples
//   WIDTH_OUT : width of the signed reconstructed output
//   LOG2_N    : log2 of the window length N, 1..8
// Ports
//   clk        (in)  : clock, everything on the rising edge
//   reset      (in)  : synchronous active-high reset, overrides everything
//   clear      (in)  : synchronous restart of the window, out holds
//   in         (in)  : signed narrow sample
//   strobe_in  (in)  : in is valid this cycle
//   out        (out) : signed decimated sample, holds between strobes
//   strobe_out (out) : single-cycle pulse, out is new this cycle
module sd_avg_decim #(
    parameter int WIDTH_IN  = 5,
    parameter int WIDTH_OUT = 8,
    parameter int LOG2_N    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic signed [WIDTH_IN-1:0]  in,
    input  logic                        strobe_in,
    output logic signed [WIDTH_OUT-1:0] out,
    output logic                        strobe_out
);

    // The window sum of N samples needs LOG2_N growth bits, which is also
    // why the accumulator can never overflow and carries no wrap handling.
    localparam int ACC_W = WIDTH_IN + LOG2_N;
    localparam int SHIFT = ACC_W - WIDTH_OUT;

    if (SHIFT < 0) begin : g_bad_shift
        $error("sd_avg_decim: WIDTH_OUT must not exceed WIDTH_IN+LOG2_N");
    end
    if (LOG2_N < 1 || LOG2_N > 8) begin : g_bad_log2n
        $error("sd_avg_decim: LOG2_N must be within 1..8");
    end

    logic        [LOG2_N-1:0]    phase;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     in_ext;
    logic signed [ACC_W-1:0]     sum;
    logic        [WIDTH_OUT-1:0] scaled;

    assign in_ext = {{LOG2_N{in[WIDTH_IN-1]}}, in};
    assign sum    = acc + in_ext;

    sd_avg_scale #(
        .ACC_W    (ACC_W),
        .WIDTH_OUT(WIDTH_OUT)
    ) u_scale (
        .sum   (sum),
        .scaled(scaled)
    );

    // Window accumulation. The last sample of a window is never stored in
    // acc: it is folded into sum combinationally and the scaled result goes
    // straight to out, so the accumulator restarts at zero on the same edge.
    // All-ones phase marks the last slot (N-1).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            phase      <= '0;
            out        <= '0;
            strobe_out <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            phase      <= '0;
            strobe_out <= 1'b0;
        end else if (strobe_in) begin
            if (&phase) begin
                out        <= scaled;
                strobe_out <= 1'b1;
                acc        <= '0;
                phase      <= '0;
            end else begin
                acc        <= sum;
                phase      <= phase + LOG2_N'(1);
                strobe_out <= 1'b0;
            end
        end else begin
            strobe_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_avg_decim.sv
// tb_sd_avg_decim
//   Self-checking bench for sd_avg_decim with WIDTH_IN=5, LOG2_N=3. Two
//   instances share the input stream: one with WIDTH_OUT=8 (no shift) and one
//   with WIDTH_OUT=6 (shift by 2, exercising truncation or rounding depending
//   on SD_AVG_DECIM_ROUND_EN). The reference model collects accepted samples
//   in a queue and computes each window's result from the plain sum.
module tb_sd_avg_decim;

    localparam int N = 8;

    logic              clk;
    logic              reset;
    logic              clear;
    logic signed [4:0] sample;
    logic              strobe_in;
    logic signed [7:0] out8;
    logic              strobe8;
    logic signed [5:0] out6;
    logic              strobe6;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    int window_q[$];
    int exp_out8;
    int exp_out6;
    logic exp_strobe;

    sd_avg_decim #(.WIDTH_IN(5), .WIDTH_OUT(8), .LOG2_N(3)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in        (sample),
        .strobe_in (strobe_in),
        .out       (out8),
        .strobe_out(strobe8)
    );

    sd_avg_decim #(.WIDTH_IN(5), .WIDTH_OUT(6), .LOG2_N(3)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in        (sample),
        .strobe_in (strobe_in),
        .out       (out6),
        .strobe_out(strobe6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected scaled value of a window sum for a given shift/output width.
    function automatic int scale_ref(input int total, input int shift, input int wout);
        int r;
        if (shift == 0) return total;
`ifdef SD_AVG_DECIM_ROUND_EN
        r = (total + (1 << (shift - 1))) >>> shift;
        if (r > (1 << (wout - 1)) - 1) r = (1 << (wout - 1)) - 1;
`else
        r = total >>> shift;
`endif
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks_total++;
        assert (got === want) checks_passed++;
        else $error("[TB] FAIL %s: got %0d (0x%h) want %0d (0x%h)",
                    tag, $signed(got), got, $signed(want), want);
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] want8;
        logic [5:0] want6;
        want8 = 8'(exp_out8);
        want6 = 6'(exp_out6);
        check_val({tag, " strobe8"}, {7'd0, strobe8}, {7'd0, exp_strobe});
        check_val({tag, " out8"}, out8, want8);
        check_val({tag, " strobe6"}, {7'd0, strobe6}, {7'd0, exp_strobe});
        check_val({tag, " out6"}, {2'b00, out6}, {2'b00, want6});
    endtask

    // Drive one cycle of inputs, let one rising edge pass, advance the
    // model by the same cycle, then compare.
    task automatic applyStimulus(input string tag, input logic r, input logic c,
                                 input logic s, input int v);
        int total;
        reset     = r;
        clear     = c;
        strobe_in = s;
        sample    = 5'(v);
        @(posedge clk);
        #1;
        exp_strobe = 1'b0;
        if (r) begin
            window_q.delete();
            exp_out8 = 0;
            exp_out6 = 0;
        end else if (c) begin
            window_q.delete();
        end else if (s) begin
            window_q.push_back(v);
            if (window_q.size() == N) begin
                total = 0;
                foreach (window_q[k]) total += window_q[k];
                exp_out8   = scale_ref(total, 0, 8);
                exp_out6   = scale_ref(total, 2, 6);
                exp_strobe = 1'b1;
                window_q.delete();
            end
        end
        checkOutput(tag);
    endtask

    initial begin
        int pattern[8];
        reset     = 1'b0;
        clear     = 1'b0;
        strobe_in = 1'b0;
        sample    = '0;
        exp_out8  = 0;
        exp_out6  = 0;
        exp_strobe = 1'b0;

        // Reset state, including reset winning over clear and strobe_in
        applyStimulus("reset", 1'b1, 1'b0, 1'b0, 0);
        applyStimulus("reset_over_all", 1'b1, 1'b1, 1'b1, 9);
        applyStimulus("idle", 1'b0, 1'b0, 1'b0, 0);

        // Constant 3 on every cycle -> 24
        for (int i = 0; i < 2 * N; i++) applyStimulus("const3", 1'b0, 1'b0, 1'b1, 3);
        applyStimulus("hold24", 1'b0, 1'b0, 1'b0, 0);

        // Most negative input -> 8'h80
        for (int i = 0; i < N; i++) applyStimulus("const_m16", 1'b0, 1'b0, 1'b1, -16);

        // Alternating extremes -> -4
        for (int i = 0; i < N; i++)
            applyStimulus("alt", 1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 15 : -16);

        // Sum 26: truncated 6 / rounded 7 on the 6-bit output
        pattern = '{4, 4, 3, 3, 3, 3, 3, 3};
        for (int i = 0; i < N; i++) applyStimulus("sum26", 1'b0, 1'b0, 1'b1, pattern[i]);

        // Gapped stream, clear after 5 strobes with a simultaneous strobe
        for (int i = 0; i < 5; i++) begin
            applyStimulus("gap_pre", 1'b0, 1'b0, 1'b1, 1);
            applyStimulus("gap_idle", 1'b0, 1'b0, 1'b0, 0);
            applyStimulus("gap_idle", 1'b0, 1'b0, 1'b0, 0);
        end
        applyStimulus("clear_wins", 1'b0, 1'b1, 1'b1, 1);
        for (int i = 0; i < N; i++) begin
            applyStimulus("gap_win", 1'b0, 1'b0, 1'b1, 1);
            applyStimulus("gap_idle", 1'b0, 1'b0, 1'b0, 0);
            applyStimulus("gap_idle", 1'b0, 1'b0, 1'b0, 0);
        end

        // Reset mid-window discards the partial sum
        for (int i = 0; i < 4; i++) applyStimulus("pre_reset", 1'b0, 1'b0, 1'b1, 7);
        applyStimulus("mid_reset", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < N; i++) applyStimulus("after_reset", 1'b0, 1'b0, 1'b1, 2);

        // Randomised traffic with occasional clear and reset
        for (int i = 0; i < 600; i++) begin
            logic r, c, s;
            int v;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 4);
            s = ($urandom_range(0, 99) < 65);
            v = int'($urandom_range(0, 31)) - 16;
            applyStimulus("random", r, c, s, v);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
